// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver.
// Covers the FSM states, the parity modes and the baud divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Truncating divisor; a zero baud rate yields 0 so callers can reject it.
  function automatic logic [31:0] calc_div(input logic [31:0] freq, input logic [31:0] baud);
    if (baud == 32'd0) calc_div = 32'd0;
    else               calc_div = freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Holds the baud divisor and counts clocks within one bit period.
// bit_end_o strobes on the last cycle of each bit.
module uart_baud_cnt import uart_pkg::*; #(
  parameter int FREQ_CLK     = 100_000_000,
  parameter int BAUD_DEFAULT = 115200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] baud_rate_i,
  input  logic        baud_we_i,
  input  logic        run_i,
  input  logic        clr_i,
  output logic        bit_end_o
);

  localparam logic [31:0] DIV_RST = calc_div(32'(FREQ_CLK), 32'(BAUD_DEFAULT));

  logic [31:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_new;

  // Divisors below 2 cannot form a bit period, so such writes are dropped.
  always_comb begin
    div_new = calc_div(32'(FREQ_CLK), baud_rate_i);
    div_d   = div_q;
    if (baud_we_i && (baud_rate_i != 32'd0) && (div_new >= 32'd2)) div_d = div_new;
  end

  assign bit_end_o = run_i && (cnt_q == div_q - 32'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = 32'd0;
    else if (run_i) cnt_d = bit_end_o ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= DIV_RST;
      cnt_q <= 32'd0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter that shifts out one accepted word per frame.
// A frame is a start bit, data bits sent LSB first, an optional parity bit and the stop bits.
module uart_tx import uart_pkg::*; #(
  parameter int FREQ_CLK     = 100_000_000,
  parameter int DATA_WDTH    = 8,
  parameter int BAUD_DEFAULT = 115200,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLKip,
  input  logic                 RSTi,
  input  logic [31:0]          BAUD_RATEi,
  input  logic                 BAUD_RATE_WEi,
  input  logic [DATA_WDTH-1:0] DATAi,
  input  logic                 VALIDi,
  output logic                 READYo,
  output logic                 TXo,
  output logic                 BUSYo,
  output logic                 DONEo
);

  localparam int IDX_W = $clog2(DATA_WDTH);

  uart_state_e          state_q;
  logic [DATA_WDTH-1:0] shreg_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;
  logic                 bit_end;

  // Handshake: a word transfers on a rising edge where VALIDi and READYo are both high.
  assign accept = (state_q == ST_IDLE) && VALIDi && ready_q;

  uart_baud_cnt #(
    .FREQ_CLK     (FREQ_CLK),
    .BAUD_DEFAULT (BAUD_DEFAULT)
  ) u_baud_cnt (
    .clk_i       (CLKip),
    .rst_i       (RSTi),
    .baud_rate_i (BAUD_RATEi),
    .baud_we_i   (BAUD_RATE_WEi && (state_q == ST_IDLE)),
    .run_i       (state_q != ST_IDLE),
    .clr_i       (accept),
    .bit_end_o   (bit_end)
  );

  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
          if (accept) begin
            shreg_q <= DATAi;
            par_q   <= ^DATAi;
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == IDX_W'(DATA_WDTH - 1)) begin
              stop_q <= 1'b0;
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PAR;
                tx_q    <= (PARITY == PAR_ODD) ? ~par_q : par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end
        end
        ST_PAR: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_q == 1'(STOP_BITS - 1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign READYo = ready_q;
  assign TXo    = tx_q;
  assign BUSYo  = busy_q;
  assign DONEo  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity/1 stop, even/1 stop, odd/2 stop) compared
// cycle by cycle with a frame model built from the framing rules, plus a loopback receiver.
module tb_uart_tx;

  localparam int FREQ = 100_000_000;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] baud_rate;
  logic        we_r    [NDUT];
  logic        valid_r [NDUT];
  logic [7:0]  data_r  [NDUT];
  logic        ready_w [NDUT];
  logic        tx_w    [NDUT];
  logic        busy_w  [NDUT];
  logic        done_w  [NDUT];

  int compared   = 0;
  int mismatched = 0;
  int div_m  [NDUT];
  int par_m  [NDUT] = '{0, 1, 2};
  int stop_m [NDUT] = '{1, 1, 2};
  logic [0:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_tx #(.FREQ_CLK(FREQ), .DATA_WDTH(8), .BAUD_DEFAULT(115200), .PARITY(0), .STOP_BITS(1)) dut0 (
    .CLKip(clk), .RSTi(rst), .BAUD_RATEi(baud_rate), .BAUD_RATE_WEi(we_r[0]),
    .DATAi(data_r[0]), .VALIDi(valid_r[0]), .READYo(ready_w[0]), .TXo(tx_w[0]),
    .BUSYo(busy_w[0]), .DONEo(done_w[0]));

  uart_tx #(.FREQ_CLK(FREQ), .DATA_WDTH(8), .BAUD_DEFAULT(115200), .PARITY(1), .STOP_BITS(1)) dut1 (
    .CLKip(clk), .RSTi(rst), .BAUD_RATEi(baud_rate), .BAUD_RATE_WEi(we_r[1]),
    .DATAi(data_r[1]), .VALIDi(valid_r[1]), .READYo(ready_w[1]), .TXo(tx_w[1]),
    .BUSYo(busy_w[1]), .DONEo(done_w[1]));

  uart_tx #(.FREQ_CLK(FREQ), .DATA_WDTH(8), .BAUD_DEFAULT(115200), .PARITY(2), .STOP_BITS(2)) dut2 (
    .CLKip(clk), .RSTi(rst), .BAUD_RATEi(baud_rate), .BAUD_RATE_WEi(we_r[2]),
    .DATAi(data_r[2]), .VALIDi(valid_r[2]), .READYo(ready_w[2]), .TXo(tx_w[2]),
    .BUSYo(busy_w[2]), .DONEo(done_w[2]));

  // Reference model: the line level for every cycle of one frame.
  task automatic build_expected(input int sel, input logic [7:0] d);
    logic [7:0] v;
    int         ones;
    v    = d;
    ones = $countones(v);
    exp_q.delete();
    repeat (div_m[sel]) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (div_m[sel]) exp_q.push_back(v[i]);
    if (par_m[sel] == 1) repeat (div_m[sel]) exp_q.push_back((ones % 2) == 1);
    if (par_m[sel] == 2) repeat (div_m[sel]) exp_q.push_back((ones % 2) == 0);
    repeat (stop_m[sel] * div_m[sel]) exp_q.push_back(1'b1);
  endtask

  // Called just after the accepting edge; checks every frame cycle, then the DONE cycle.
  task automatic check_frame(input int sel, input logic [7:0] d, input string name);
    int         len;
    int         bad;
    int         first_bad;
    logic [0:0] want;
    build_expected(sel, d);
    len       = exp_q.size();
    bad       = 0;
    first_bad = -1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      if (tx_w[sel] !== want[0] || busy_w[sel] !== 1'b1 || ready_w[sel] !== 1'b0 ||
          done_w[sel] !== 1'b0) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL %s frame: %0d wrong cycles of %0d (first at cycle %0d), data=%h div=%0d, required 0 wrong",
               name, bad, len, first_bad, d, div_m[sel]);
    end
    @(negedge clk);
    compared++;
    if ({done_w[sel], busy_w[sel], ready_w[sel]} !== 3'b101) begin
      mismatched++;
      $display("FAIL %s end: done/busy/ready=%b%b%b required 101",
               name, done_w[sel], busy_w[sel], ready_w[sel]);
    end
  endtask

  task automatic send_word(input int sel, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (ready_w[sel] !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout dut%0d: ready=%b required 1", sel, ready_w[sel]);
    end
    valid_r[sel] = 1'b1;
    data_r[sel]  = d;
    @(posedge clk);
    #1;
    valid_r[sel] = 1'b0;
  endtask

  task automatic write_baud(input int sel, input logic [31:0] rate);
    @(negedge clk);
    baud_rate = rate;
    we_r[sel] = 1'b1;
    @(posedge clk);
    #1;
    we_r[sel] = 1'b0;
    if (rate != 32'd0 && (32'(FREQ) / rate) >= 32'd2) div_m[sel] = int'(32'(FREQ) / rate);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < NDUT; s++) begin
      compared++;
      if ({tx_w[s], ready_w[s], busy_w[s], done_w[s]} !== 4'b1000) begin
        mismatched++;
        $display("FAIL reset_outputs dut%0d: tx/ready/busy/done=%b%b%b%b required 1000",
                 s, tx_w[s], ready_w[s], busy_w[s], done_w[s]);
      end
    end
    rst = 1'b0;
    #1;
    compared++;
    if (ready_w[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_before_edge: ready=%b required 0", ready_w[0]);
    end
    @(negedge clk);
    for (int s = 0; s < NDUT; s++) begin
      compared++;
      if (ready_w[s] !== 1'b1) begin
        mismatched++;
        $display("FAIL ready_after_release dut%0d: ready=%b required 1", s, ready_w[s]);
      end
    end
  endtask

  task automatic test_default_div();
    send_word(0, 8'h3C);
    check_frame(0, 8'h3C, "default_div");
  endtask

  task automatic test_basic();
    logic [7:0] d;
    for (int s = 0; s < NDUT; s++) write_baud(s, 32'd10_000_000);
    send_word(0, 8'hA5);
    check_frame(0, 8'hA5, "basic_a5");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send_word(0, d);
      check_frame(0, d, "basic_random");
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    send_word(1, 8'h07);
    check_frame(1, 8'h07, "even_parity_07");
    send_word(2, 8'h07);
    check_frame(2, 8'h07, "odd_parity_07");
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      send_word(1, d);
      check_frame(1, d, "even_parity_random");
      d = 8'($urandom_range(0, 255));
      send_word(2, d);
      check_frame(2, d, "odd_parity_random");
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    valid_r[0] = 1'b1;
    data_r[0]  = 8'h55;
    @(posedge clk);
    #1;
    data_r[0] = 8'hAA;
    check_frame(0, 8'h55, "b2b_first");
    @(posedge clk);
    #1;
    valid_r[0] = 1'b0;
    check_frame(0, 8'hAA, "b2b_second");
  endtask

  task automatic test_baud_writes();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    send_word(0, d);
    fork
      check_frame(0, d, "mid_write_frame");
      begin
        repeat (30) @(negedge clk);
        baud_rate = 32'd5_000_000;
        we_r[0]   = 1'b1;
        @(negedge clk);
        we_r[0] = 1'b0;
      end
    join
    send_word(0, 8'h96);
    check_frame(0, 8'h96, "after_mid_write");
    write_baud(0, 32'd0);
    send_word(0, 8'h3A);
    check_frame(0, 8'h3A, "zero_baud_ignored");
    write_baud(0, 32'd60_000_000);
    send_word(0, 8'hC1);
    check_frame(0, 8'hC1, "div1_ignored");
    write_baud(0, 32'd50_000_000);
    send_word(0, 8'h5E);
    check_frame(0, 8'h5E, "div2_accepted");
    @(negedge clk);
    baud_rate  = 32'd25_000_000;
    we_r[0]    = 1'b1;
    valid_r[0] = 1'b1;
    data_r[0]  = 8'h81;
    @(posedge clk);
    #1;
    we_r[0]    = 1'b0;
    valid_r[0] = 1'b0;
    div_m[0]   = 4;
    check_frame(0, 8'h81, "write_with_accept");
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    int tx_low;
    write_baud(0, 32'd10_000_000);
    send_word(0, 8'hF7);
    repeat (45) @(negedge clk);
    compared++;
    if (tx_w[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL bit3_before_reset: tx=%b required 0", tx_w[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({tx_w[0], ready_w[0], busy_w[0], done_w[0]} !== 4'b1000) begin
      mismatched++;
      $display("FAIL async_reset: tx/ready/busy/done=%b%b%b%b required 1000",
               tx_w[0], ready_w[0], busy_w[0], done_w[0]);
    end
    for (int s = 0; s < NDUT; s++) div_m[s] = FREQ / 115200;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (ready_w[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_mid_reset: ready=%b required 1", ready_w[0]);
    end
    done_seen = 0;
    tx_low    = 0;
    repeat (150) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) done_seen++;
      if (tx_w[0] !== 1'b1) tx_low++;
    end
    compared++;
    if (done_seen != 0 || tx_low != 0) begin
      mismatched++;
      $display("FAIL aborted_frame: done pulses=%0d tx-low cycles=%0d required 0 and 0",
               done_seen, tx_low);
    end
  endtask

  task automatic test_loopback();
    bit         rx_timeout;
    write_baud(0, 32'd50_000_000);
    sent_q.delete();
    rx_q.delete();
    rx_timeout = 1'b0;
    fork
      begin
        logic [7:0] d;
        for (int w = 0; w < 256; w++) begin
          d = 8'($urandom_range(0, 255));
          sent_q.push_back(d);
          send_word(0, d);
        end
      end
      begin
        logic [7:0] r;
        int         t;
        for (int w = 0; w < 256 && !rx_timeout; w++) begin
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (tx_w[0] !== 1'b0 && t < 200);
          if (t >= 200) begin
            rx_timeout = 1'b1;
          end else begin
            for (int i = 0; i < 8; i++) begin
              repeat (div_m[0]) @(negedge clk);
              r[i] = tx_w[0];
            end
            repeat (div_m[0]) @(negedge clk);
            if (tx_w[0] !== 1'b1) r = ~r;
            rx_q.push_back(r);
          end
        end
      end
    join
    compared++;
    if (rx_timeout || rx_q.size() != sent_q.size()) begin
      mismatched++;
      $display("FAIL loopback_count: received %0d words required %0d", rx_q.size(), sent_q.size());
    end
    for (int w = 0; w < rx_q.size() && w < sent_q.size(); w++) begin
      compared++;
      if (rx_q[w] !== sent_q[w]) begin
        mismatched++;
        $display("FAIL loopback_word %0d: got %h required %h", w, rx_q[w], sent_q[w]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    baud_rate = 32'd0;
    for (int s = 0; s < NDUT; s++) begin
      we_r[s]    = 1'b0;
      valid_r[s] = 1'b0;
      data_r[s]  = 8'h00;
      div_m[s]   = FREQ / 115200;
    end
    test_reset();
    test_default_div();
    test_basic();
    test_parity();
    test_back_to_back();
    test_baud_writes();
    test_reset_mid_frame();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises parallel words into asynchronous frames on a single line. It is the counterpart of the `uart_rx` receiver: its `TXo` drives the wire that the receiver's `RXi` samples. It shares the same parameter set and baud-rate programming so the two ends can be configured identically. Upstream logic hands it words through a valid/ready handshake.

## Interface
- `FREQ_CLK`, 100_000_000: clock frequency in Hz.
- `DATA_WDTH`, 8: data bits per frame, range 5..9.
- `BAUD_DEFAULT`, 115200: baud rate loaded at reset.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports, clock and reset first:
- `CLKip`  in  1  clock; one clock domain.
- `RSTi`  in  1  reset, asynchronous, active-high.
- `BAUD_RATEi`  in  32  requested baud rate in Hz.
- `BAUD_RATE_WEi`  in  1  load `BAUD_RATEi` into the divisor register.
- `DATAi`  in  `DATA_WDTH`  word to send.
- `VALIDi`  in  1  `DATAi` is valid.
- `READYo`  out  1  transmitter can accept a word.
- `TXo`  out  1  serial line; idles high.
- `BUSYo`  out  1  a frame is in progress.
- `DONEo`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Divisor:
  - `DIV = FREQ_CLK / BAUD_RATEi`, 32-bit unsigned integer division, truncated.
  - Registered on a cycle where `BAUD_RATE_WEi`=1 and the state is IDLE.
  - Ignored when `BAUD_RATEi`=0 or the computed `DIV` < 2.
  - Ignored when not IDLE; the write is dropped, not deferred.
- Reset divisor is `FREQ_CLK / BAUD_DEFAULT`.
- Frame format, each bit held for `DIV` cycles:
  - start bit (0);
  - `DATA_WDTH` data bits, LSB first;
  - optional parity bit (even: XOR of data bits; odd: its inverse);
  - `STOP_BITS` stop bits (1).
- Handshake:
  - A word is accepted on a rising edge where `VALIDi`=1 and `READYo`=1.
  - `DATAi` is latched into a shift register at that edge.
  - `READYo`=1 only in IDLE.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE→START on accept.
  - START→DATA after `DIV` cycles.
  - DATA→PAR after `DATA_WDTH` bits when `PARITY`≠0; otherwise DATA→STOP.
  - PAR→STOP after `DIV` cycles.
  - STOP→IDLE after `STOP_BITS`×`DIV` cycles.
- Counters:
  - Bit-period counter runs 0..`DIV`-1 and wraps to 0 at every bit boundary.
  - Bit index is `$clog2(DATA_WDTH)` bits wide and resets to 0 on entry to DATA.
- Simultaneous baud write and accept in IDLE: both take effect, and the frame uses the new divisor.
- Reset mid-frame aborts the frame:
  - `TXo` returns to 1 asynchronously.
  - State returns to IDLE; the word is lost and `DONEo` does not pulse.

## Timing
- During reset: `TXo`=1, `READYo`=0, `BUSYo`=0, `DONEo`=0, state IDLE. `READYo` rises on the first clock edge after `RSTi` falls.
- All outputs are registered; no combinational path from any input to any output.
- Accept at edge *n*:
  - `TXo`=0 and `BUSYo`=1 from edge *n*+1.
  - `READYo`=0 from edge *n*+1.
- Frame length `L` = (1 + `DATA_WDTH` + (`PARITY`≠0) + `STOP_BITS`) × `DIV` cycles, measured from edge *n*+1.
- At the end of the frame (edge *n*+1+`L`):
  - `DONEo`=1 for exactly one cycle.
  - `BUSYo`=0 and `READYo`=1 in the same cycle.
- Back-to-back: if `VALIDi` is held, the next accept occurs at edge *n*+1+`L`. The next start bit follows one cycle later, so `TXo` stays high for `L_stop`+1 cycles between frames.
- A new divisor applies from the next frame's start bit.

## Structure
- Shared package `uart_pkg`:
  - state enum;
  - parity-mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - function computing `DIV`.
- One sub-module `uart_baud_cnt`:
  - holds `DIV`;
  - runs the bit-period counter;
  - emits a one-cycle `bit_end` strobe.
- It uses the same async reset as the parent and is reusable by the receiver.

## Test plan
- Set `FREQ_CLK`=100 MHz and write `BAUD_RATEi`=10_000_000 (`DIV`=10), `PARITY`=0; send 0xA5.
  - `TXo` = 0,1,0,1,0,0,1,0,1,1, each for 10 cycles.
  - `DONEo` pulses at 100 cycles after accept+1.
- With `PARITY`=1, send 0x07 → parity bit 1. With `PARITY`=2, send 0x07 → parity bit 0. Frame is 110 cycles.
- Hold `VALIDi` high with 0x55 then 0xAA:
  - second accept coincides with the first `DONEo`;
  - exactly 1 idle-high cycle between frames.
- Baud write cases:
  - Write `BAUD_RATEi`=5_000_000 mid-frame → ignored; the next frame still uses `DIV`=10.
  - Write 0 in IDLE → ignored.
  - Write 50_000_000 (`DIV`=2) in IDLE → accepted.
- Assert `RSTi` during data bit 3:
  - `TXo`=1 immediately;
  - no `DONEo`;
  - `READYo`=1 one edge after release.
- Loopback `TXo`→`uart_rx.RXi` at matching baud, 256 random words → every word received intact.
